// File: rtl/counter_pkg.sv
// Shared types and helpers for tick-based countdown timers.
// Prescaler sizing lives here so the display-refresh logic can reuse it.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  function automatic int div_of(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int presc_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Gated prescaler: counts 0..DIV-1 while enabled, holds otherwise, clr zeroes it.
// tick is a pure decode of the count register, so it is glitch-free.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = presc_w(DIV);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown controller: load / run / pause / expire life cycle around a gated tick prescaler.
// Holds only the FSM and the remaining-ticks register; timing phase lives in the prescaler.
module countdown_sequencer
  import counter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             pause_tog,
  input  logic             cancel,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             paused,
  output logic             expired,
  output logic             done,
  output logic             tick
);

  localparam int DIV = div_of(CLK_HZ, TICK_HZ);

  cd_state_t        r_state;
  cd_state_t        w_state_next;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_rem_next;
  logic             r_zero_done;
  logic             w_zero_next;
  logic             r_busy;
  logic             r_paused;
  logic             r_expired;
  logic             w_presc_tick;
  logic             w_presc_en;
  logic             w_presc_clr;
  logic             w_tick;

  // A pause landing on the wrap cycle freezes the prescaler at DIV-1 so the
  // dropped tick fires on the first RUN cycle after resume.
  assign w_presc_en  = (r_state == RUN) && !(pause_tog && w_presc_tick);
  assign w_presc_clr = cancel || start || (r_state == IDLE) || (r_state == DONE);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_presc_en),
    .clr  (w_presc_clr),
    .tick (w_presc_tick)
  );

  assign w_tick = (r_state == RUN) && w_presc_tick;

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_remaining;
    w_zero_next  = 1'b0;
    if (cancel) begin
      w_state_next = IDLE;
      w_rem_next   = '0;
    end else if (start) begin
      w_rem_next = load_val;
      if (load_val != '0) begin
        w_state_next = RUN;
      end else begin
        w_state_next = DONE;
        w_zero_next  = 1'b1;
      end
    end else if (pause_tog && (r_state == RUN)) begin
      w_state_next = PAUSE;
    end else if (pause_tog && (r_state == PAUSE)) begin
      w_state_next = RUN;
    end else if (w_tick && (r_remaining != '0)) begin
      w_rem_next = r_remaining - CNT_W'(1);
      if (r_remaining == CNT_W'(1)) begin
        w_state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_zero_done <= 1'b0;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_rem_next;
      r_zero_done <= w_zero_next;
      r_busy      <= (w_state_next == RUN) || (w_state_next == PAUSE);
      r_paused    <= (w_state_next == PAUSE);
      r_expired   <= (w_state_next == DONE);
    end
  end

  // Terminal tick pulses done in the tick cycle; a zero-length load pulses it
  // in the first DONE cycle via r_zero_done.
  assign done      = (w_tick && (r_remaining == CNT_W'(1))) || r_zero_done;
  assign tick      = w_tick;
  assign remaining = r_remaining;
  assign busy      = r_busy;
  assign paused    = r_paused;
  assign expired   = r_expired;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with a cycle-level behavioural model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_countdown_sequencer;

  localparam int CNT_W = 8;
  localparam int DIV   = 10;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             pause_tog = 1'b0;
  logic             cancel = 1'b0;
  logic [CNT_W-1:0] remaining;
  logic             busy, paused, expired, done, tick;

  int n_checks = 0;
  int n_errors = 0;
  int rel = 0;

  // model state: phase, ticks left, cycles until the next tick, zero-load flag
  int m_st = S_IDLE;
  int m_rem = 0;
  int m_to_tick = DIV;
  bit m_zero = 1'b0;
  bit m_valid = 1'b0;

  countdown_sequencer #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_val  (load_val),
    .pause_tog (pause_tog),
    .cancel    (cancel),
    .remaining (remaining),
    .busy      (busy),
    .paused    (paused),
    .expired   (expired),
    .done      (done),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare the model's view of this cycle, then advance it with this cycle's inputs.
  always @(negedge clk) begin
    bit m_tick;
    bit m_done;
    m_tick = (m_st == S_RUN) && (m_to_tick == 1);
    m_done = (m_tick && (m_rem == 1)) || m_zero;
    if (m_valid) begin
      chk("remaining", int'(remaining), m_rem);
      chk("busy", int'(busy), int'(m_st == S_RUN || m_st == S_PAUSE));
      chk("paused", int'(paused), int'(m_st == S_PAUSE));
      chk("expired", int'(expired), int'(m_st == S_DONE));
      chk("tick", int'(tick), int'(m_tick));
      chk("done", int'(done), int'(m_done));
    end
    m_zero = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_st = S_IDLE;
      m_rem = 0;
      m_to_tick = DIV;
    end else if (cancel) begin
      m_st = S_IDLE;
      m_rem = 0;
      m_to_tick = DIV;
    end else if (start) begin
      m_rem = int'(load_val);
      m_to_tick = DIV;
      if (load_val != 0) begin
        m_st = S_RUN;
      end else begin
        m_st = S_DONE;
        m_zero = 1'b1;
      end
    end else if (pause_tog && m_st == S_RUN) begin
      m_st = S_PAUSE;
      if (!m_tick) m_to_tick = m_to_tick - 1;
    end else if (pause_tog && m_st == S_PAUSE) begin
      m_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (m_tick) begin
        m_to_tick = DIV;
        if (m_rem == 1) m_st = S_DONE;
        if (m_rem > 0) m_rem = m_rem - 1;
      end else begin
        m_to_tick = m_to_tick - 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    start = 1'b0;
    pause_tog = 1'b0;
    cancel = 1'b0;
    rel++;
    $display("cycle rel=%0d rem=%0d busy=%0b paused=%0b expired=%0b done=%0b tick=%0b",
             rel, remaining, busy, paused, expired, done, tick);
  endtask

  task automatic run_to(input int target);
    while (rel < target) cyc();
  endtask

  task automatic start_cmd(input int v);
    start = 1'b1;
    load_val = CNT_W'(v);
    rel = 0;
    cyc();
  endtask

  task automatic cancel_cmd();
    cancel = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_remaining", int'(remaining), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_expired", int'(expired), 0);

    // 1: load 3, ticks at +10/+20/+30, done at +30
    start_cmd(3);
    run_to(10);
    chk("t1_tick10", int'(tick), 1);
    chk("t1_rem10", int'(remaining), 3);
    run_to(30);
    chk("t1_done30", int'(done), 1);
    cyc();
    chk("t1_expired31", int'(expired), 1);
    chk("t1_rem31", int'(remaining), 0);
    cancel_cmd();

    // 2: load 5, pause at +14, resume at +40, tick at +46, last tick at +76
    start_cmd(5);
    run_to(14);
    pause_tog = 1'b1;
    cyc();
    run_to(40);
    chk("t2_rem_paused", int'(remaining), 4);
    chk("t2_paused", int'(paused), 1);
    pause_tog = 1'b1;
    cyc();
    run_to(45);
    chk("t2_no_tick45", int'(tick), 0);
    cyc();
    chk("t2_tick46", int'(tick), 1);
    run_to(76);
    chk("t2_done76", int'(done), 1);
    cancel_cmd();

    // 3: cancel mid-run
    start_cmd(4);
    run_to(25);
    cancel_cmd();
    chk("t3_busy", int'(busy), 0);
    chk("t3_rem", int'(remaining), 0);

    // 4: restart with a new load at +15
    start_cmd(2);
    run_to(15);
    start_cmd(6);
    run_to(10);
    chk("t4_tick25", int'(tick), 1);
    chk("t4_rem25", int'(remaining), 6);
    run_to(60);
    chk("t4_done75", int'(done), 1);
    cancel_cmd();

    // 5: zero load goes straight to DONE
    start_cmd(0);
    chk("t5_done", int'(done), 1);
    chk("t5_expired", int'(expired), 1);
    chk("t5_tick", int'(tick), 0);
    cyc();
    chk("t5_done_gone", int'(done), 0);
    cancel_cmd();

    // 7: pause on the tick cycle drops it; it fires right after resume
    start_cmd(2);
    run_to(10);
    pause_tog = 1'b1;
    cyc();
    run_to(20);
    chk("t7_rem_held", int'(remaining), 2);
    pause_tog = 1'b1;
    cyc();
    chk("t7_tick21", int'(tick), 1);
    run_to(31);
    chk("t7_done31", int'(done), 1);
    cancel_cmd();

    // 6: reset mid-pause, later pause_tog ignored
    start_cmd(5);
    run_to(3);
    pause_tog = 1'b1;
    cyc();
    run_to(8);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_paused", int'(paused), 0);
    chk("t6_rem", int'(remaining), 0);
    pause_tog = 1'b1;
    cyc();
    cyc();
    chk("t6_busy_after_tog", int'(busy), 0);
    chk("t6_paused_after_tog", int'(paused), 0);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
